// File: rtl/int_pkg.sv
// Shared types and constants for the interrupt unit: FSM states, PC mux
// select encodings and a width helper for interrupt indices.
package int_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ENTER   = 2'b01,
        SERVICE = 2'b10,
        RETURN  = 2'b11
    } state_e;

    localparam logic [1:0] PC_SEL_SEQ = 2'b00;
    localparam logic [1:0] PC_SEL_BR  = 2'b01;
    localparam logic [1:0] PC_SEL_VEC = 2'b10;
    localparam logic [1:0] PC_SEL_EPC = 2'b11;

    // Width needed to hold an index in [0, n-1], never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/irq_pending.sv
// Edge capture, pending register, mask register and lowest-index priority
// encoder for the external interrupt lines.
module irq_pending
    import int_pkg::*;
#(
    parameter int NUM_IRQ = 4,
    parameter int IDX_W   = idx_width(NUM_IRQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [NUM_IRQ-1:0] ack,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_wdata,
    output logic               req_valid,
    output logic [IDX_W-1:0]   req_idx
);

    logic [NUM_IRQ-1:0] irq_prev_q, irq_prev_d;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] mask_q, mask_d;
    logic [NUM_IRQ-1:0] req;

    // A new edge on a bit beats its acknowledge in the same cycle.
    always_comb begin
        irq_prev_d = irq_in;
        pending_d  = (pending_q & ~ack) | (irq_in & ~irq_prev_q);
        mask_d     = mask_we ? mask_wdata : mask_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_prev_q <= '0;
            pending_q  <= '0;
            mask_q     <= '1;
        end else begin
            irq_prev_q <= irq_prev_d;
            pending_q  <= pending_d;
            mask_q     <= mask_d;
        end
    end

    assign req       = pending_q & mask_q;
    assign req_valid = |req;

    always_comb begin
        req_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) req_idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/interrupt_unit.sv
// Interrupt controller driving the PC-source mux select of the pipelined core.
// Define INT_NEST_EN to allow higher-priority requests to preempt a handler.
module interrupt_unit
    import int_pkg::*;
#(
    parameter int                NUM_IRQ    = 4,
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] VEC_BASE   = 32'h0000_0080,
    parameter logic [ADDR_W-1:0] VEC_STRIDE = 32'h0000_0010
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_wdata,
    input  logic               safe_pt,
    input  logic [ADDR_W-1:0]  resume_pc,
    input  logic               branch_taken,
    input  logic               eret_in,
    output logic [1:0]         pc_sel,
    output logic [ADDR_W-1:0]  vec_addr,
    output logic [ADDR_W-1:0]  epc_out,
    output logic               flush,
    output logic [NUM_IRQ-1:0] int_ack,
    output logic               in_service
);

    localparam int IDX_W = idx_width(NUM_IRQ);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   epc_q, epc_d;
    logic [ADDR_W-1:0]   vec_q, vec_d;
    logic                flush_q, flush_d;
    logic [NUM_IRQ-1:0]  int_ack_q, int_ack_d;
    logic                redirect_q, redirect_d;
    logic                sel_lo_q, sel_lo_d;
    logic                take;
    logic                req_valid;
    logic [IDX_W-1:0]    req_idx;

`ifdef INT_NEST_EN
    localparam int SP_W = idx_width(NUM_IRQ + 1);

    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [ADDR_W-1:0] stk_epc_q [NUM_IRQ];
    logic [ADDR_W-1:0] stk_epc_d [NUM_IRQ];
    logic [IDX_W-1:0]  stk_idx_q [NUM_IRQ];
    logic [IDX_W-1:0]  stk_idx_d [NUM_IRQ];
    logic [SP_W-1:0]   sp_q, sp_d;
    logic [SP_W-1:0]   sp_top;

    assign sp_top = sp_q - SP_W'(1);
`endif

    irq_pending #(
        .NUM_IRQ (NUM_IRQ),
        .IDX_W   (IDX_W)
    ) u_pending (
        .clk        (clk),
        .rst_n      (rst_n),
        .irq_in     (irq_in),
        .ack        (int_ack_q),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .req_valid  (req_valid),
        .req_idx    (req_idx)
    );

    function automatic logic [ADDR_W-1:0] vec_of(input logic [IDX_W-1:0] idx);
        return VEC_BASE + ADDR_W'(idx) * VEC_STRIDE;
    endfunction

    always_comb begin
        state_d    = state_q;
        epc_d      = epc_q;
        vec_d      = vec_q;
        flush_d    = 1'b0;
        int_ack_d  = '0;
        redirect_d = 1'b0;
        sel_lo_d   = 1'b0;
        take       = 1'b0;
`ifdef INT_NEST_EN
        idx_d      = idx_q;
        stk_epc_d  = stk_epc_q;
        stk_idx_d  = stk_idx_q;
        sp_d       = sp_q;
`endif
        case (state_q)
            IDLE: take = req_valid && safe_pt;
            ENTER: state_d = SERVICE;
            SERVICE: begin
                if (eret_in) begin
                    state_d    = RETURN;
                    flush_d    = 1'b1;
                    redirect_d = PC_SEL_EPC[1];
                    sel_lo_d   = PC_SEL_EPC[0];
                end
`ifdef INT_NEST_EN
                else if (req_valid && safe_pt && (req_idx < idx_q)) begin
                    take                          = 1'b1;
                    stk_epc_d[sp_q[IDX_W-1:0]]    = epc_q;
                    stk_idx_d[sp_q[IDX_W-1:0]]    = idx_q;
                    sp_d                          = sp_q + SP_W'(1);
                end
`endif
            end
            RETURN: begin
`ifdef INT_NEST_EN
                // Returning from a nested handler resumes the preempted one.
                if (sp_q != '0) begin
                    state_d = SERVICE;
                    epc_d   = stk_epc_q[sp_top[IDX_W-1:0]];
                    idx_d   = stk_idx_q[sp_top[IDX_W-1:0]];
                    sp_d    = sp_top;
                end else
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (take) begin
            state_d    = ENTER;
            epc_d      = resume_pc;
            vec_d      = vec_of(req_idx);
            flush_d    = 1'b1;
            int_ack_d  = NUM_IRQ'(1) << req_idx;
            redirect_d = PC_SEL_VEC[1];
            sel_lo_d   = PC_SEL_VEC[0];
`ifdef INT_NEST_EN
            idx_d      = req_idx;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            epc_q      <= '0;
            vec_q      <= '0;
            flush_q    <= 1'b0;
            int_ack_q  <= '0;
            redirect_q <= 1'b0;
            sel_lo_q   <= 1'b0;
`ifdef INT_NEST_EN
            idx_q      <= '0;
            sp_q       <= '0;
            for (int i = 0; i < NUM_IRQ; i++) begin
                stk_epc_q[i] <= '0;
                stk_idx_q[i] <= '0;
            end
`endif
        end else begin
            state_q    <= state_d;
            epc_q      <= epc_d;
            vec_q      <= vec_d;
            flush_q    <= flush_d;
            int_ack_q  <= int_ack_d;
            redirect_q <= redirect_d;
            sel_lo_q   <= sel_lo_d;
`ifdef INT_NEST_EN
            idx_q      <= idx_d;
            sp_q       <= sp_d;
            stk_epc_q  <= stk_epc_d;
            stk_idx_q  <= stk_idx_d;
`endif
        end
    end

    // Only branch_taken reaches pc_sel combinationally, and only outside redirects.
    assign pc_sel     = {redirect_q, redirect_q ? sel_lo_q : branch_taken};
    assign vec_addr   = vec_q;
    assign epc_out    = epc_q;
    assign flush      = flush_q;
    assign int_ack    = int_ack_q;
    assign in_service = (state_q == SERVICE);

endmodule

// File: tb/tb_interrupt_unit.sv
// Self-checking bench for interrupt_unit: a table of directed vectors plus
// hand-written sequences for safe-point stalls, collisions and reset.
module tb_interrupt_unit;

   typedef struct packed {
      logic [3:0]  irq;
      logic        mask_we;
      logic [3:0]  mask_wdata;
      logic        safe;
      logic [31:0] pc;
      logic        br;
      logic        eret;
   } stim_t;

   typedef struct packed {
      logic [1:0]  pc_sel;
      logic [31:0] vec;
      logic [31:0] epc;
      logic        flush;
      logic [3:0]  ack;
      logic        insvc;
   } exp_t;

   typedef struct packed {
      stim_t s;
      exp_t  e;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic [3:0]  irq_in;
   logic        mask_we;
   logic [3:0]  mask_wdata;
   logic        safe_pt;
   logic [31:0] resume_pc;
   logic        branch_taken;
   logic        eret_in;
   logic [1:0]  pc_sel;
   logic [31:0] vec_addr;
   logic [31:0] epc_out;
   logic        flush;
   logic [3:0]  int_ack;
   logic        in_service;

   int checks;
   int failures;
   vec_t tbl[$];

   interrupt_unit #(
      .NUM_IRQ    (4),
      .ADDR_W     (32),
      .VEC_BASE   (32'h0000_0080),
      .VEC_STRIDE (32'h0000_0010)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .irq_in       (irq_in),
      .mask_we      (mask_we),
      .mask_wdata   (mask_wdata),
      .safe_pt      (safe_pt),
      .resume_pc    (resume_pc),
      .branch_taken (branch_taken),
      .eret_in      (eret_in),
      .pc_sel       (pc_sel),
      .vec_addr     (vec_addr),
      .epc_out      (epc_out),
      .flush        (flush),
      .int_ack      (int_ack),
      .in_service   (in_service)
   );

   // Free-running 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case the stimulus ever stalls
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Builds a stimulus record
   function automatic stim_t st(input logic [3:0] irq, input logic mwe, input logic [3:0] mwd,
                                input logic safe, input logic [31:0] pc, input logic br,
                                input logic eret);
      stim_t s;
      s.irq = irq; s.mask_we = mwe; s.mask_wdata = mwd; s.safe = safe;
      s.pc = pc; s.br = br; s.eret = eret;
      return s;
   endfunction

   // Builds an expected-output record
   function automatic exp_t ex(input logic [1:0] ps, input logic [31:0] vec, input logic [31:0] epc,
                               input logic fl, input logic [3:0] ack, input logic insvc);
      exp_t e;
      e.pc_sel = ps; e.vec = vec; e.epc = epc; e.flush = fl; e.ack = ack; e.insvc = insvc;
      return e;
   endfunction

   // Appends one vector to the table
   task automatic addVec(input stim_t s, input exp_t e);
      vec_t v;
      v.s = s;
      v.e = e;
      tbl.push_back(v);
   endtask

   // Drives all DUT inputs from a stimulus record
   task automatic applyStimulus(input stim_t s);
      irq_in       = s.irq;
      mask_we      = s.mask_we;
      mask_wdata   = s.mask_wdata;
      safe_pt      = s.safe;
      resume_pc    = s.pc;
      branch_taken = s.br;
      eret_in      = s.eret;
   endtask

   // Compares one field and records the result
   task automatic cmpField(input string name, input string field, input logic [31:0] got,
                           input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("[TB] FAIL %s.%s got=%h expected=%h", name, field, got, want);
      end
   endtask

   // Compares every output against an expected record
   task automatic checkOutput(input exp_t e, input string name);
      cmpField(name, "pc_sel",     32'(pc_sel),     32'(e.pc_sel));
      cmpField(name, "vec_addr",   vec_addr,        e.vec);
      cmpField(name, "epc_out",    epc_out,         e.epc);
      cmpField(name, "flush",      32'(flush),      32'(e.flush));
      cmpField(name, "int_ack",    32'(int_ack),    32'(e.ack));
      cmpField(name, "in_service", 32'(in_service), 32'(e.insvc));
   endtask

   // One clock cycle: drive just after the rising edge, check 1 ns later
   task automatic cycle(input stim_t s, input exp_t e, input string name);
      @(posedge clk);
      #1;
      applyStimulus(s);
      #1;
      checkOutput(e, name);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      applyStimulus(st(4'h0, 1'b0, 4'h0, 1'b0, 32'h0, 1'b0, 1'b0));

      // Basic entry on irq 2, then eret back to IDLE
      addVec(st(4'h0,0,4'h0,1,32'h400,0,0), ex(2'b00,32'h00,32'h000,0,4'h0,0));
      addVec(st(4'h4,0,4'h0,1,32'h400,1,0), ex(2'b01,32'h00,32'h000,0,4'h0,0));
      addVec(st(4'h0,0,4'h0,1,32'h400,0,0), ex(2'b00,32'h00,32'h000,0,4'h0,0));
      addVec(st(4'h0,0,4'h0,1,32'h400,1,0), ex(2'b10,32'hA0,32'h400,1,4'h4,0));
      addVec(st(4'h0,0,4'h0,1,32'h400,0,0), ex(2'b00,32'hA0,32'h400,0,4'h0,1));
      addVec(st(4'h0,0,4'h0,1,32'h400,1,0), ex(2'b01,32'hA0,32'h400,0,4'h0,1));
      addVec(st(4'h0,0,4'h0,1,32'h400,0,1), ex(2'b00,32'hA0,32'h400,0,4'h0,1));
      addVec(st(4'h0,0,4'h0,1,32'h400,1,0), ex(2'b11,32'hA0,32'h400,1,4'h0,0));
      addVec(st(4'h0,0,4'h0,1,32'h400,0,0), ex(2'b00,32'hA0,32'h400,0,4'h0,0));
      // Priority: irq 1 and 3 together, 1 first then 3
      addVec(st(4'hA,0,4'h0,1,32'h500,0,0), ex(2'b00,32'hA0,32'h400,0,4'h0,0));
      addVec(st(4'h0,0,4'h0,1,32'h500,0,0), ex(2'b00,32'hA0,32'h400,0,4'h0,0));
      addVec(st(4'h0,0,4'h0,1,32'h500,0,0), ex(2'b10,32'h90,32'h500,1,4'h2,0));
      addVec(st(4'h0,0,4'h0,1,32'h500,0,1), ex(2'b00,32'h90,32'h500,0,4'h0,1));
      addVec(st(4'h0,0,4'h0,1,32'h500,0,0), ex(2'b11,32'h90,32'h500,1,4'h0,0));
      addVec(st(4'h0,0,4'h0,1,32'h600,0,0), ex(2'b00,32'h90,32'h500,0,4'h0,0));
      addVec(st(4'h0,0,4'h0,1,32'h600,1,0), ex(2'b10,32'hB0,32'h600,1,4'h8,0));
      addVec(st(4'h0,0,4'h0,1,32'h600,0,1), ex(2'b00,32'hB0,32'h600,0,4'h0,1));
      addVec(st(4'h0,0,4'h0,1,32'h600,0,0), ex(2'b11,32'hB0,32'h600,1,4'h0,0));
      addVec(st(4'h0,0,4'h0,1,32'h600,0,0), ex(2'b00,32'hB0,32'h600,0,4'h0,0));
      // Masking: irq 0 masked off, then re-enabled
      addVec(st(4'h0,1,4'hE,1,32'h600,0,0), ex(2'b00,32'hB0,32'h600,0,4'h0,0));
      addVec(st(4'h1,0,4'h0,1,32'h600,0,0), ex(2'b00,32'hB0,32'h600,0,4'h0,0));
      addVec(st(4'h0,0,4'h0,1,32'h600,1,0), ex(2'b01,32'hB0,32'h600,0,4'h0,0));
      addVec(st(4'h0,1,4'hF,1,32'h700,0,0), ex(2'b00,32'hB0,32'h600,0,4'h0,0));
      addVec(st(4'h0,0,4'h0,1,32'h700,0,0), ex(2'b00,32'hB0,32'h600,0,4'h0,0));
      addVec(st(4'h0,0,4'h0,1,32'h700,0,0), ex(2'b10,32'h80,32'h700,1,4'h1,0));
      addVec(st(4'h0,0,4'h0,1,32'h700,0,1), ex(2'b00,32'h80,32'h700,0,4'h0,1));
      addVec(st(4'h0,0,4'h0,1,32'h700,0,0), ex(2'b11,32'h80,32'h700,1,4'h0,0));
      addVec(st(4'h0,0,4'h0,1,32'h700,0,0), ex(2'b00,32'h80,32'h700,0,4'h0,0));

      // Reset and check the reset values before the first active edge
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      #1;
      checkOutput(ex(2'b00,32'h0,32'h0,0,4'h0,0), "reset");

      for (int i = 0; i < tbl.size(); i++) begin
         cycle(tbl[i].s, tbl[i].e, $sformatf("vec%0d", i));
      end

      // Safe point held low for 5 cycles: branch passes through, no ack
      cycle(st(4'h4,0,4'h0,0,32'h800,0,0), ex(2'b00,32'h80,32'h700,0,4'h0,0), "safe0");
      for (int i = 1; i <= 5; i++) begin
         cycle(st(4'h0,0,4'h0,0,32'h800,1'(i % 2),0),
               ex({1'b0, 1'(i % 2)},32'h80,32'h700,0,4'h0,0), $sformatf("safe_hold%0d", i));
      end
      cycle(st(4'h0,0,4'h0,1,32'h800,0,0), ex(2'b00,32'h80,32'h700,0,4'h0,0), "safe_rise");
      // Fresh edge on irq 2 during its own ack cycle keeps it pending
      cycle(st(4'h4,0,4'h0,1,32'h800,0,0), ex(2'b10,32'hA0,32'h800,1,4'h4,0), "coll_enter");
      cycle(st(4'h0,0,4'h0,1,32'h800,0,0), ex(2'b00,32'hA0,32'h800,0,4'h0,1), "coll_svc");
      cycle(st(4'h0,0,4'h0,1,32'h800,0,1), ex(2'b00,32'hA0,32'h800,0,4'h0,1), "coll_nopreempt");
      cycle(st(4'h0,0,4'h0,1,32'h900,0,0), ex(2'b11,32'hA0,32'h800,1,4'h0,0), "coll_ret");
      cycle(st(4'h0,0,4'h0,1,32'h900,0,0), ex(2'b00,32'hA0,32'h800,0,4'h0,0), "coll_idle");
      cycle(st(4'h0,0,4'h0,1,32'h900,0,0), ex(2'b10,32'hA0,32'h900,1,4'h4,0), "coll_reenter");
      cycle(st(4'h0,0,4'h0,1,32'h900,0,1), ex(2'b00,32'hA0,32'h900,0,4'h0,1), "coll_svc2");
      cycle(st(4'h0,0,4'h0,1,32'h900,0,0), ex(2'b11,32'hA0,32'h900,1,4'h0,0), "coll_ret2");
      // eret while IDLE must be ignored
      cycle(st(4'h0,0,4'h0,1,32'h900,0,1), ex(2'b00,32'hA0,32'h900,0,4'h0,0), "eret_idle");
      cycle(st(4'h0,0,4'h0,1,32'h900,0,0), ex(2'b00,32'hA0,32'h900,0,4'h0,0), "eret_idle_after");

      // Reset while in SERVICE with irq 3 left pending
      cycle(st(4'h2,0,4'h0,1,32'hA00,0,0), ex(2'b00,32'hA0,32'h900,0,4'h0,0), "rst_pulse");
      cycle(st(4'h0,0,4'h0,1,32'hA00,0,0), ex(2'b00,32'hA0,32'h900,0,4'h0,0), "rst_pend");
      cycle(st(4'h0,0,4'h0,1,32'hA00,0,0), ex(2'b10,32'h90,32'hA00,1,4'h2,0), "rst_enter");
      cycle(st(4'h8,0,4'h0,1,32'hA00,0,0), ex(2'b00,32'h90,32'hA00,0,4'h0,1), "rst_svc");
      cycle(st(4'h0,0,4'h0,1,32'hA00,0,0), ex(2'b00,32'h90,32'hA00,0,4'h0,1), "rst_svc2");
      rst_n = 1'b0;
      #1;
      checkOutput(ex(2'b00,32'h0,32'h0,0,4'h0,0), "rst_async");
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle(st(4'h0,0,4'h0,1,32'hB00,0,0), ex(2'b00,32'h0,32'h0,0,4'h0,0),
               $sformatf("rst_nopend%0d", i));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/interrupt_unit.md
# interrupt_unit

Interrupt controller for the pipelined MIPS core; it drives the 2-bit select of the PC-source 4:1 mux directly.
- Latches rising edges on external IRQ lines, applies a mask, and picks the highest-priority pending source at a safe pipeline point.
- On entry it redirects fetch to that source's vector and flushes the pipeline; on `eret` it returns to the saved EPC.
- Between those events it passes the branch/jump redirect through.

## Interface
- NUM_IRQ, 4: number of interrupt lines; index 0 has the highest priority.
- ADDR_W, 32: PC and address width.
- VEC_BASE, 32'h0000_0080: vector address of IRQ 0.
- VEC_STRIDE, 32'h0000_0010: address spacing between consecutive vectors.
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- irq_in  in  NUM_IRQ  external requests; rising-edge sensitive, one-cycle minimum pulse.
- mask_we  in  1  write strobe for the mask register.
- mask_wdata  in  NUM_IRQ  new mask value; 1 = enabled.
- safe_pt  in  1  EX stage holds a valid, non-stalled, non-delay-slot instruction.
- resume_pc  in  ADDR_W  PC of the oldest unretired instruction, captured as EPC.
- branch_taken  in  1  branch/jump redirect request from ID/EX.
- eret_in  in  1  `eret` decoded in EX.
- pc_sel  out  2  PC mux select: 00 = PC+4, 01 = branch target, 10 = vector, 11 = EPC.
- vec_addr  out  ADDR_W  vector address; valid while pc_sel = 10.
- epc_out  out  ADDR_W  saved return address.
- flush  out  1  flush IF/ID/EX registers.
- int_ack  out  NUM_IRQ  one-hot acknowledge pulse, one cycle.
- in_service  out  1  a handler is active.

## Operation
- **Pending capture.** Each bit of the pending register is set on a 0→1 transition of `irq_in` (previous value registered). It is cleared by its own `int_ack`. If an edge and an ack hit the same bit in the same cycle, set wins.
- **Selection.** The request vector is `pending & mask`. The winner is its lowest set index.
- **Vector address.** `vec_addr = VEC_BASE + idx*VEC_STRIDE`, computed at ADDR_W, wrapping modulo 2^ADDR_W.
- **States:** IDLE, ENTER, SERVICE, RETURN.
- **IDLE → ENTER** when the request vector is nonzero and `safe_pt` = 1. In that cycle the unit latches EPC ← `resume_pc` and the winning index.
- **ENTER** lasts one cycle: pc_sel = 10, flush = 1, and int_ack pulses the winning bit. Next state is SERVICE.
- **SERVICE:** in_service = 1. On `eret_in` = 1 → RETURN. New requests stay pending and are not taken.
- **RETURN** lasts one cycle: pc_sel = 11, flush = 1. Next state is IDLE.
- **IDLE and SERVICE outputs:** pc_sel = {1'b0, branch_taken}, flush = 0.
- **Ignored inputs:** `eret_in` in IDLE, ENTER or RETURN has no effect. In ENTER and RETURN, `branch_taken` is ignored because the interrupt redirect wins.
- **Mask writes** take effect the following cycle and are allowed in any state. The mask gates only selection, never capture.

## Timing
- **Reset values:** pc_sel = 00, vec_addr = 0, epc_out = 0, flush = 0, int_ack = 0, in_service = 0. Internally: state = IDLE, pending = 0, mask = all ones.
- **Reset mid-operation** from any state returns to IDLE immediately and drops all pending requests.
- **Entry latency:** `irq_in` edge in cycle N sets pending at N+1. If `safe_pt` is high at N+1, ENTER is at N+2 and SERVICE at N+3.
- **Return latency:** `eret_in` in cycle M → RETURN at M+1 → IDLE at M+2. A request still pending can enter again at M+3 at the earliest.
- **Registered outputs:** pc_sel bit 1, flush, int_ack, vec_addr and epc_out all come from registers.
- **Combinational path:** only `branch_taken` reaches pc_sel bit 0.

## Configuration
- **INT_NEST_EN undefined:** behaviour exactly as above; no preemption.
- **INT_NEST_EN defined:** in SERVICE, a masked-in pending request with index lower than the active index, together with `safe_pt`, causes ENTER.
  - The current EPC and active index are pushed onto a NUM_IRQ-deep stack.
  - `eret` pops the stack and stays in SERVICE with the popped index; RETURN still drives the popped EPC.
  - IDLE is reached only when the stack is empty.

## Structure
- **Package `int_pkg`:** state enum; PC_SEL_SEQ/BR/VEC/EPC constants (00/01/10/11).
- **Sub-module `irq_pending`:** edge detect, pending register, masking, and priority encoder. Outputs are `req_valid` and `req_idx`.

## Test plan
- **Basic entry/return:** NUM_IRQ = 4, pulse irq_in[2], safe_pt = 1, resume_pc = 0x400 → ENTER two cycles later: pc_sel = 10, vec_addr = 0xA0, flush = 1, int_ack = 0100, epc_out = 0x400. Then `eret` → pc_sel = 11, then IDLE.
- **Priority:** irq 1 and irq 3 pulse in the same cycle → irq 1 acknowledged first (vec 0x90). After `eret`, irq 3 entered (vec 0xB0).
- **Masking:** mask = 1110, pulse irq 0 → no entry. Write mask = 1111 → entry with vec 0x80.
- **Safe point:** safe_pt held 0 for 5 cycles with a pending request → pc_sel follows branch_taken, no ack. safe_pt → 1 enters the next cycle.
- **Collision cases:** an irq edge on the same bit during its ack cycle → bit stays pending and re-enters after return. `eret` in IDLE → no change.
- **Reset:** assert rst_n low while in SERVICE → all outputs at reset values, pending = 0.
